module_output_disp_7seg: RTL and testbench

- Downstream display stage for the Gray decoder.
- Takes the decoder's binary result and converts it to BCD with a sequential double-dabble engine.
- Drives a time-multiplexed, common-anode 7-segment display (active-low anodes and segments).
- Converted value commits atomically, so the display never shows a partial conversion.

---
 rtl/disp_pkg.sv | 55 +++++
 rtl/module_bin_to_bcd.sv | 94 +++++++++
 rtl/module_output_disp_7seg.sv | 100 ++++++++++
 tb/tb_module_output_disp_7seg.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment display stage: segment codes for a
// common-anode display ({g,f,e,d,c,b,a}, active-low), BCD nibble width,
// the binary-to-BCD FSM state encoding and a couple of helpers.
package disp_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } bcd_state_t;

  // Non-decimal nibbles map to a dark digit rather than a hex glyph.
  function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Elaboration-time helper for the digit-count range check.
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/module_bin_to_bcd.sv
// Sequential double-dabble converter. The BCD output only changes in
// COMMIT, so downstream logic never sees a half-shifted value.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | waiting for bin_i to differ from the last converted value
//   ST_LOAD   | shift register holds {zeros, bin_i}; iteration count loaded
//   ST_SHIFT  | one add-3/shift-left step per cycle, WIDTH steps total
//   ST_COMMIT | BCD result copied to bcd_o
//
// Register updates are keyed on the state being entered, so the load
// happens on the IDLE->LOAD edge and the commit on the SHIFT->COMMIT edge.
// That keeps the whole conversion at WIDTH+2 edges after the input
// register changes.
module module_bin_to_bcd
  import disp_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int N_DIGITS = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [WIDTH-1:0]          bin_i,
  output logic [BCD_W*N_DIGITS-1:0] bcd_o,
  output logic                      busy_o
);

  localparam int BCD_BITS = BCD_W * N_DIGITS;
  localparam int SR_W     = BCD_BITS + WIDTH;
  localparam int IT_W     = $clog2(WIDTH + 1);

  bcd_state_t         state_q, state_d;
  logic [SR_W-1:0]    sr_q;
  logic [WIDTH-1:0]   last_q;
  logic [IT_W-1:0]    iter_q;
  logic [BCD_BITS-1:0] bcd_q;

  // One double-dabble step: correct each BCD nibble, then shift left.
  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] r;
    r = v;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (r[WIDTH + BCD_W*d +: BCD_W] >= 4'd5)
        r[WIDTH + BCD_W*d +: BCD_W] = r[WIDTH + BCD_W*d +: BCD_W] + 4'd3;
    end
    return r << 1;
  endfunction

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bin_i != last_q) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_SHIFT;
      ST_SHIFT:  if (iter_q == '0) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath actions performed on entry to each state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sr_q   <= '0;
      last_q <= '0;
      iter_q <= '0;
      bcd_q  <= '0;
    end else begin
      case (state_d)
        ST_LOAD: begin
          sr_q   <= {{BCD_BITS{1'b0}}, bin_i};
          last_q <= bin_i;
          iter_q <= IT_W'(WIDTH);
        end
        ST_SHIFT: begin
          sr_q   <= dabble(sr_q);
          iter_q <= iter_q - IT_W'(1);
        end
        ST_COMMIT: bcd_q <= sr_q[SR_W-1 -: BCD_BITS];
        default: ;
      endcase
    end
  end

  assign bcd_o  = bcd_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/module_output_disp_7seg.sv
// Display stage after the Gray decoder: samples the binary code, converts
// it to BCD and scans it onto a common-anode multiplexed 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN darkens zero digits above the
// most significant nonzero digit (digit 0 always lit).
module module_output_disp_7seg
  import disp_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int N_DIGITS     = 2,
  parameter int SCAN_REFRESH = 100000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WIDTH-1:0]    codigo_bin_i,
  output logic [N_DIGITS-1:0] anodo_o,
  output logic [6:0]          seg_o,
  output logic                busy_o
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = (SCAN_REFRESH > 1) ? $clog2(SCAN_REFRESH) : 1;
  localparam logic [CNT_W-1:0] SCAN_RELOAD = CNT_W'(SCAN_REFRESH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_DIGITS - 1);

  if (((longint'(1) << WIDTH) - 1) >= pow10(N_DIGITS)) begin : g_range_check
    $error("module_output_disp_7seg: N_DIGITS too small for WIDTH");
  end

  logic [WIDTH-1:0]                sample_q;
  logic [N_DIGITS-1:0][BCD_W-1:0]  bcd;
  logic [CNT_W-1:0]                scan_cnt_q;
  logic [IDX_W-1:0]                idx_q;
  logic [BCD_W-1:0]                nib;
  logic [N_DIGITS-1:0]             lz_blank;
  logic [6:0]                      seg_d;

  // Input sample register feeding the converter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sample_q <= '0;
    else        sample_q <= codigo_bin_i;
  end

  module_bin_to_bcd #(
    .WIDTH    (WIDTH),
    .N_DIGITS (N_DIGITS)
  ) u_bin_to_bcd (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bin_i  (sample_q),
    .bcd_o  (bcd),
    .busy_o (busy_o)
  );

  // Scan timer: down-counter, digit advances on terminal count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scan_cnt_q <= SCAN_RELOAD;
      idx_q      <= '0;
    end else if (scan_cnt_q == '0) begin
      scan_cnt_q <= SCAN_RELOAD;
      idx_q      <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      scan_cnt_q <= scan_cnt_q - CNT_W'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_run;

  // Mark zero digits that have only zeros above them; digit 0 stays lit.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int d = N_DIGITS - 1; d > 0; d--) begin
      lz_run      = lz_run & (bcd[d] == '0);
      lz_blank[d] = lz_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Segment pattern for the digit currently selected by the scan.
  always_comb begin
    nib   = bcd[idx_q];
    seg_d = lz_blank[idx_q] ? SEG_BLANK : seg_decode(nib);
  end

  // Anode and segment registers switch on the same edge to avoid ghosting.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      anodo_o <= '1;
      seg_o   <= SEG_BLANK;
    end else begin
      anodo_o <= ~(N_DIGITS'(1) << idx_q);
      seg_o   <= seg_d;
    end
  end

endmodule

// File: tb/tb_module_output_disp_7seg.sv
// Bench for module_output_disp_7seg with a fast scan (4 cycles per digit).
module tb_module_output_disp_7seg;

  localparam int WIDTH    = 4;
  localparam int N_DIGITS = 2;
  localparam int SCAN     = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [3:0] codigo_bin_i = 4'd0;
  logic [1:0] anodo_o;
  logic [6:0] seg_o;
  logic       busy_o;

  int n_err    = 0;
  int n_checks = 0;
  int cyc      = 0;

  always #5 clk_i = ~clk_i;

  module_output_disp_7seg #(
    .WIDTH        (WIDTH),
    .N_DIGITS     (N_DIGITS),
    .SCAN_REFRESH (SCAN)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .codigo_bin_i (codigo_bin_i),
    .anodo_o      (anodo_o),
    .seg_o        (seg_o),
    .busy_o       (busy_o)
  );

  function automatic logic [6:0] numeral(input int n);
    case (n)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected segments for decimal digit d of value v.
  function automatic logic [6:0] exp_seg(input int v, input int d);
    int digit;
    digit = (v / (10 ** d)) % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && v < 10 ** d) return 7'h7F;
`endif
    return numeral(digit);
  endfunction

  function automatic logic [7:0] exp_bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    cyc++;
  endtask

  // Two full scan rounds with a stable value: anode order and segments.
  task automatic check_display(input int v);
    int d;
    logic [1:0] exp_an;
    for (int i = 0; i < N_DIGITS * SCAN; i++) begin
      step();
      d = ((cyc - 1) / SCAN) % N_DIGITS;
      exp_an = 2'b11;
      exp_an[d] = 1'b0;
      chk("anodo_scan", 32'(anodo_o), 32'(exp_an));
      chk("seg_digit", 32'(seg_o), 32'(exp_seg(v, d)));
    end
    chk("busy_idle", 32'(busy_o), 32'(1'b0));
  endtask

  // Drive a new value and check conversion timing, then the display.
  task automatic convert(input int v, input int prev);
    codigo_bin_i = 4'(v);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (v != prev) begin
        chk("busy_window", 32'(busy_o), 32'((k >= 2 && k <= 7) ? 1'b1 : 1'b0));
        if (k == 6) chk("bcd_before_commit", 32'(dut.bcd), 32'(exp_bcd(prev)));
        if (k == 7) chk("bcd_at_commit", 32'(dut.bcd), 32'(exp_bcd(v)));
      end else begin
        chk("busy_no_change", 32'(busy_o), 32'(1'b0));
      end
    end
    chk("bcd_final", 32'(dut.bcd), 32'(exp_bcd(v)));
    check_display(v);
  endtask

  initial begin
    int prev;
    int v;
    int pulses;
    int bad_vals;
    logic busy_prev;

    // Reset held from time zero.
    repeat (3) @(negedge clk_i);
    chk("rst_anodo", 32'(anodo_o), 32'(2'b11));
    chk("rst_seg", 32'(seg_o), 32'(7'h7F));
    chk("rst_busy", 32'(busy_o), 32'(1'b0));
    chk("rst_bcd", 32'(dut.bcd), 32'(8'h00));

    // Release: first edge lights digit 0 with "0".
    rst_i = 1'b1;
    cyc = 0;
    step();
    chk("first_anodo", 32'(anodo_o), 32'(2'b10));
    chk("first_seg", 32'(seg_o), 32'(7'h40));
    check_display(0);
    check_display(0);
    prev = 0;

    // Conversion of 13.
    convert(13, prev);
    prev = 13;

    // Change of input two cycles into a running conversion.
    convert(0, prev);
    codigo_bin_i = 4'd13;
    pulses = 0;
    bad_vals = 0;
    busy_prev = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 2) codigo_bin_i = 4'd7;
      if (busy_o && !busy_prev) pulses++;
      busy_prev = busy_o;
      if (!(dut.bcd inside {8'h00, 8'h13, 8'h07})) bad_vals++;
      if (k == 6)  chk("mid_bcd_k6", 32'(dut.bcd), 32'(8'h00));
      if (k == 7)  chk("mid_bcd_k7", 32'(dut.bcd), 32'(8'h13));
      if (k == 13) chk("mid_bcd_k13", 32'(dut.bcd), 32'(8'h13));
      if (k == 14) chk("mid_bcd_k14", 32'(dut.bcd), 32'(8'h07));
    end
    chk("mid_busy_pulses", 32'(pulses), 32'(2));
    chk("mid_no_stray_value", 32'(bad_vals), 32'(0));
    check_display(7);
    prev = 7;

    // Reset in the middle of SHIFT.
    codigo_bin_i = 4'd12;
    repeat (4) step();
    chk("shift_busy", 32'(busy_o), 32'(1'b1));
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy_o), 32'(1'b0));
    chk("async_rst_anodo", 32'(anodo_o), 32'(2'b11));
    chk("async_rst_seg", 32'(seg_o), 32'(7'h7F));
    codigo_bin_i = 4'd9;
    step();
    step();
    rst_i = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 2) chk("post_rst_busy", 32'(busy_o), 32'(1'b1));
      if (k == 6) chk("post_rst_bcd_k6", 32'(dut.bcd), 32'(8'h00));
      if (k == 7) chk("post_rst_bcd_k7", 32'(dut.bcd), 32'(8'h09));
    end
    check_display(9);
    prev = 9;

    // Boundary values, then random values.
    for (int i = 0; i < 20; i++) begin
      case (i)
        0: v = 15;
        1: v = 10;
        2: v = 0;
        3: v = 0;
        default: v = int'($urandom_range(0, 15));
      endcase
      convert(v, prev);
      prev = v;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
